// File: rtl/branch_update_queue_pkg.sv
// branch_update_queue_pkg: queue depth default, entry width and field offsets.
package branch_update_queue_pkg;
  localparam int BUQ_DEPTH_BITS = 3;
  localparam int BUQ_ENTRY_W = 35;
  localparam int BUQ_PRED_OFF = 0;
  localparam int BUQ_BHT_OFF = 1;
  localparam int BUQ_PHT_OFF = 2;
  localparam int BUQ_ADDR_OFF = 3;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/branch_update_fifo.sv
// branch_update_fifo: circular entry storage with pointers, count and a clear that overrides push/pop.
module branch_update_fifo
  import branch_update_queue_pkg::*;
#(
  parameter int DB = BUQ_DEPTH_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [BUQ_ENTRY_W-1:0] wdata_i,
  output logic [BUQ_ENTRY_W-1:0] rdata_o,
  output logic                   full_o,
  output logic                   empty_o
);
  logic [DB-1:0] head_q, tail_q;
  logic [DB:0] count_q;
  logic [BUQ_ENTRY_W-1:0] mem_q [2**DB];
  assign rdata_o = mem_q[head_q];
  assign full_o = count_q[DB];
  assign empty_o = count_q == '0;
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_q + DB'(pop_i);
      tail_q <= tail_q + DB'(push_i);
      count_q <= count_q + (DB+1)'(push_i) - (DB+1)'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[tail_q] <= wdata_i;
  end
endmodule

// File: rtl/branch_update_queue.sv
// branch_update_queue: in-order branch prediction record, retired at EX into the predictor correct port.
// Optional BUQ_PERF_CNT_EN adds saturating resolved/mispredict/dropped counters.
module branch_update_queue
  import branch_update_queue_pkg::*;
#(
  parameter int DEPTH_BITS = BUQ_DEPTH_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_valid_i,
  input  logic [31:0] push_addr_i,
  input  logic        push_pht_flag_i,
  input  logic        push_bht_flag_i,
  input  logic        push_pred_flag_i,
  output logic        push_ready_o,
  input  logic        res_valid_i,
  input  logic [31:0] res_addr_i,
  input  logic        res_taken_i,
  input  logic        flush_i,
  output logic        corr_valid_o,
  output logic [31:0] corr_addr_o,
  output logic        corr_pht_branch_flag_o,
  output logic        corr_bht_branch_flag_o,
  output logic        corr_branch_flag_o,
  output logic        mispredict_o,
  output logic        desync_o
`ifdef BUQ_PERF_CNT_EN
  ,
  output logic [31:0] perf_resolved_o,
  output logic [31:0] perf_mispred_o,
  output logic [31:0] perf_dropped_o
`endif
);
  logic [BUQ_ENTRY_W-1:0] head;
  logic full, empty, push_ok, pop_req, hit, retire, desync, miss;
  logic corr_valid_q, corr_valid_d, corr_pht_q, corr_pht_d, corr_bht_q, corr_bht_d;
  logic corr_flag_q, corr_flag_d, mispredict_q, mispredict_d, desync_q, desync_d;
  logic [31:0] corr_addr_q, corr_addr_d;
  assign push_ready_o = !full;
  assign push_ok = push_valid_i && !full && !flush_i;
  assign pop_req = res_valid_i && !empty;
  assign hit = head[BUQ_ADDR_OFF +: 32] == res_addr_i;
  assign retire = pop_req && hit;
  assign desync = pop_req && !hit;
  assign miss = retire && (head[BUQ_PRED_OFF] ^ res_taken_i);
  // The head is retired before a same-cycle flush or desync wipes the queue.
  branch_update_fifo #(.DB(DEPTH_BITS)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush_i || desync),
    .push_i  (push_ok),
    .pop_i   (retire),
    .wdata_i ({push_addr_i, push_pht_flag_i, push_bht_flag_i, push_pred_flag_i}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );
  always_comb begin
    corr_valid_d = retire;
    mispredict_d = miss;
    desync_d = desync;
    corr_addr_d = retire ? head[BUQ_ADDR_OFF +: 32] : corr_addr_q;
    corr_pht_d = retire ? head[BUQ_PHT_OFF] : corr_pht_q;
    corr_bht_d = retire ? head[BUQ_BHT_OFF] : corr_bht_q;
    corr_flag_d = retire ? res_taken_i : corr_flag_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_valid_q <= 1'b0;
      corr_addr_q <= '0;
      corr_pht_q <= 1'b0;
      corr_bht_q <= 1'b0;
      corr_flag_q <= 1'b0;
      mispredict_q <= 1'b0;
      desync_q <= 1'b0;
    end else begin
      corr_valid_q <= corr_valid_d;
      corr_addr_q <= corr_addr_d;
      corr_pht_q <= corr_pht_d;
      corr_bht_q <= corr_bht_d;
      corr_flag_q <= corr_flag_d;
      mispredict_q <= mispredict_d;
      desync_q <= desync_d;
    end
  end
  assign corr_valid_o = corr_valid_q;
  assign corr_addr_o = corr_addr_q;
  assign corr_pht_branch_flag_o = corr_pht_q;
  assign corr_bht_branch_flag_o = corr_bht_q;
  assign corr_branch_flag_o = corr_flag_q;
  assign mispredict_o = mispredict_q;
  assign desync_o = desync_q;
`ifdef BUQ_PERF_CNT_EN
  logic [31:0] perf_res_q, perf_mis_q, perf_drop_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_res_q <= '0;
      perf_mis_q <= '0;
      perf_drop_q <= '0;
    end else begin
      perf_res_q <= sat_inc(perf_res_q, retire);
      perf_mis_q <= sat_inc(perf_mis_q, miss);
      perf_drop_q <= sat_inc(perf_drop_q, push_valid_i && !flush_i && (full || desync));
    end
  end
  assign perf_resolved_o = perf_res_q;
  assign perf_mispred_o = perf_mis_q;
  assign perf_dropped_o = perf_drop_q;
`endif
endmodule

// File: tb/tb_branch_update_queue.sv
// tb_branch_update_queue: directed vectors with hand-computed expectations for branch_update_queue.
module tb_branch_update_queue;
  logic clk = 1'b0, rst = 1'b1;
  logic push_valid = 1'b0, push_pht = 1'b0, push_bht = 1'b0, push_pred = 1'b0;
  logic [31:0] push_addr = '0, res_addr = '0;
  logic res_valid = 1'b0, res_taken = 1'b0, flush = 1'b0;
  logic push_ready, corr_valid, corr_pht, corr_bht, corr_flag, mispredict, desync;
  logic [31:0] corr_addr;
  int total = 0, bad = 0;
`ifdef BUQ_PERF_CNT_EN
  logic [31:0] perf_resolved, perf_mispred, perf_dropped;
`endif
  always #5 clk = ~clk;
  branch_update_queue dut (
    .clk                    (clk),
    .rst                    (rst),
    .push_valid_i           (push_valid),
    .push_addr_i            (push_addr),
    .push_pht_flag_i        (push_pht),
    .push_bht_flag_i        (push_bht),
    .push_pred_flag_i       (push_pred),
    .push_ready_o           (push_ready),
    .res_valid_i            (res_valid),
    .res_addr_i             (res_addr),
    .res_taken_i            (res_taken),
    .flush_i                (flush),
    .corr_valid_o           (corr_valid),
    .corr_addr_o            (corr_addr),
    .corr_pht_branch_flag_o (corr_pht),
    .corr_bht_branch_flag_o (corr_bht),
    .corr_branch_flag_o     (corr_flag),
    .mispredict_o           (mispredict),
    .desync_o               (desync)
`ifdef BUQ_PERF_CNT_EN
    ,
    .perf_resolved_o        (perf_resolved),
    .perf_mispred_o         (perf_mispred),
    .perf_dropped_o         (perf_dropped)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] a, input logic p, input logic b, input logic f);
    push_valid = 1'b1;
    push_addr = a;
    push_pht = p;
    push_bht = b;
    push_pred = f;
    tick();
    push_valid = 1'b0;
  endtask
  task automatic resolve(input logic [31:0] a, input logic t);
    res_valid = 1'b1;
    res_addr = a;
    res_taken = t;
    tick();
    res_valid = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", push_ready, 1);
    chk("rst_valid", corr_valid, 0);
    chk("rst_addr", corr_addr, 0);
    chk("rst_misp", mispredict, 0);
    chk("rst_desync", desync, 0);
    push(32'h100, 1, 0, 1);
    resolve(32'h100, 1);
    chk("t1_valid", corr_valid, 1);
    chk("t1_addr", corr_addr, 32'h100);
    chk("t1_pht", corr_pht, 1);
    chk("t1_bht", corr_bht, 0);
    chk("t1_flag", corr_flag, 1);
    chk("t1_misp", mispredict, 0);
    tick();
    chk("t1_pulse", corr_valid, 0);
    chk("t1_hold", corr_addr, 32'h100);
    push(32'h200, 0, 1, 1);
    resolve(32'h200, 0);
    chk("t2_valid", corr_valid, 1);
    chk("t2_flag", corr_flag, 0);
    chk("t2_bht", corr_bht, 1);
    chk("t2_misp", mispredict, 1);
    tick();
    chk("t2_misp_pulse", mispredict, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t3_ready_fill", push_ready, 1);
      push(32'(i * 4), i[1], i[2], i[0]);
    end
    chk("t3_full", push_ready, 0);
    push(32'h20, 0, 0, 0);
    chk("t3_still_full", push_ready, 0);
`ifdef BUQ_PERF_CNT_EN
    chk("t3_dropped", perf_dropped, 1);
`endif
    for (int i = 0; i < 8; i++) begin
      resolve(32'(i * 4), 1);
      chk("t3_valid", corr_valid, 1);
      chk("t3_addr", corr_addr, 32'(i * 4));
      chk("t3_pht", corr_pht, 32'(i[1]));
      chk("t3_misp", mispredict, 32'(!i[0]));
    end
    chk("t3_ready_after", push_ready, 1);
    resolve(32'h20, 1);
    chk("t3_empty_valid", corr_valid, 0);
    chk("t3_empty_desync", desync, 0);
    push(32'h300, 0, 0, 0);
    push(32'h304, 0, 0, 0);
    push(32'h308, 0, 0, 0);
    flush = 1'b1;
    resolve(32'h300, 0);
    flush = 1'b0;
    chk("t4_valid", corr_valid, 1);
    chk("t4_addr", corr_addr, 32'h300);
    resolve(32'h304, 0);
    chk("t4_after_valid", corr_valid, 0);
    chk("t4_after_desync", desync, 0);
    flush = 1'b1;
    push(32'h500, 0, 0, 0);
    flush = 1'b0;
    resolve(32'h500, 0);
    chk("t4_push_flush", corr_valid, 0);
    push(32'h400, 0, 0, 1);
    push(32'h408, 0, 0, 1);
    resolve(32'h404, 1);
    chk("t5_desync", desync, 1);
    chk("t5_valid", corr_valid, 0);
    chk("t5_misp", mispredict, 0);
    resolve(32'h408, 1);
    chk("t5_cleared", corr_valid, 0);
    chk("t5_desync_pulse", desync, 0);
    push(32'h600, 1, 1, 0);
    push_valid = 1'b1;
    push_addr = 32'h604;
    push_pht = 1'b0;
    push_bht = 1'b0;
    push_pred = 1'b1;
    resolve(32'h600, 0);
    push_valid = 1'b0;
    chk("pp_addr0", corr_addr, 32'h600);
    chk("pp_bht0", corr_bht, 1);
    resolve(32'h604, 1);
    chk("pp_valid1", corr_valid, 1);
    chk("pp_addr1", corr_addr, 32'h604);
    for (int i = 0; i < 5; i++) push(32'h700 + 32'(i * 4), 1, 1, 1);
    rst = 1'b1;
    resolve(32'h700, 0);
    chk("t6_valid", corr_valid, 0);
    chk("t6_addr", corr_addr, 0);
    chk("t6_misp", mispredict, 0);
    chk("t6_ready", push_ready, 1);
    rst = 1'b0;
    tick();
    chk("t6_cancel", corr_valid, 0);
    resolve(32'h700, 0);
    chk("t6_empty", corr_valid, 0);
    chk("t6_desync", desync, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
